// File: rtl/stat_disp_ctrl_pkg.sv
// Shared selector codes, cathode patterns and helpers for the
// statistics display scheduler.
package stat_disp_ctrl_pkg;

  localparam logic [2:0] SEL_CYCLES  = 3'd0;
  localparam logic [2:0] SEL_UNCOND  = 3'd1;
  localparam logic [2:0] SEL_COND    = 3'd2;
  localparam logic [2:0] SEL_CONDSUC = 3'd3;
  localparam logic [2:0] SEL_SYSCALL = 3'd4;
  localparam logic [2:0] SEL_LAST    = 3'd4;

  // Active-low cathodes {dp, g..a}
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_CONV,
    BCD_DONE
  } bcd_st_e;

  function automatic logic [2:0] next_sel(
    input logic [2:0] s
  );
    return (s == SEL_LAST) ? SEL_CYCLES : s + 3'd1;
  endfunction

  // Add-3 pass of double dabble over ten BCD digits
  function automatic logic [39:0] dd_adj(
    input logic [39:0] b
  );
    logic [39:0] r;
    logic [3:0]  n;
    r = b;
    for (int d = 0; d < 10; d++) begin
      n = b[4*d +: 4];
      if (n >= 4'd5) r[4*d +: 4] = n + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/stat_disp_ctrl_seg7_decode.sv
// Hex nibble to active-low seven-segment pattern (g..a).
// Ports: nib_i 4-bit value, seg_o 7-bit segments.
module seg7_decode (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/stat_disp_ctrl.sv
// Statistics display scheduler: selects a counter (button or
// auto-rotate), snapshots it per frame and scans it onto an
// 8-digit active-low seven-segment display.
// Ports: clk, rst (sync, active-high); five 32-bit counter
// sources; sel_btn (async button); auto_en; cur_sel; seg_an;
// seg_cat {dp, g..a}.
// Option: define STAT_DISP_BCD_EN for decimal display through a
// sequential double-dabble converter (hex display otherwise).
module stat_disp_ctrl
  import stat_disp_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int ROTATE_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total_cycles,
  input  logic [31:0] uncondi_num,
  input  logic [31:0] condi_num,
  input  logic [31:0] condi_suc_num,
  input  logic [31:0] SyscallOut,
  input  logic        sel_btn,
  input  logic        auto_en,
  output logic [2:0]  cur_sel,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW =
    (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(ROTATE_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    cat_q, cat_d;
  logic          s1_q, s2_q, prev_q;
  logic [31:0]   snap_q;

  logic          scan_tick, frame_b;
  logic          btn_evt, rot_evt;
  logic          dp_on;
  logic [31:0]   src;
  logic [3:0]    nib;
  logic [6:0]    seg;

  always_comb begin
    src = 32'd0;
    case (sel_q)
      SEL_CYCLES:  src = total_cycles;
      SEL_UNCOND:  src = uncondi_num;
      SEL_COND:    src = condi_num;
      SEL_CONDSUC: src = condi_suc_num;
      SEL_SYSCALL: src = SyscallOut;
      default:     src = 32'd0;
    endcase
  end

  assign nib = snap_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_dec (
    .nib_i (nib),
    .seg_o (seg)
  );

  always_comb begin
    scan_tick = (cnt_q == CNT_LAST);
    frame_b   = scan_tick && (idx_q == 3'd7);
    btn_evt   = s2_q && !prev_q;
    rot_evt   = frame_b && auto_en && (fc_q == FC_LAST);

    cnt_d = scan_tick ? '0 : cnt_q + 1'b1;
    idx_d = scan_tick ? idx_q + 3'd1 : idx_q;

    fc_d = fc_q;
    if (!auto_en)     fc_d = '0;
    else if (rot_evt) fc_d = '0;
    else if (frame_b) fc_d = fc_q + 1'b1;

    // Simultaneous button and rotate events still step once
    sel_d = (btn_evt || rot_evt) ? next_sel(sel_q) : sel_q;

    // Anode and cathode latch the digit being left behind,
    // so both move together one cycle after scan_tick
    an_d  = scan_tick ? ~(8'd1 << idx_q) : an_q;
    cat_d = scan_tick ? {~dp_on, seg} : cat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      fc_q   <= '0;
      sel_q  <= SEL_CYCLES;
      an_q   <= 8'hFF;
      cat_q  <= SEG_BLANK;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      fc_q   <= fc_d;
      sel_q  <= sel_d;
      an_q   <= an_d;
      cat_q  <= cat_d;
      s1_q   <= sel_btn;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

`ifdef STAT_DISP_BCD_EN

  bcd_st_e     st_q;
  logic [31:0] bin_q;
  logic [39:0] bcd_q;
  logic [39:0] bcd_adj;
  logic [4:0]  step_q;
  logic        ovf_q;

  assign bcd_adj = dd_adj(bcd_q);
  assign dp_on   = ovf_q && (idx_q == 3'd7);

  // Boundaries seen outside IDLE are dropped; the old
  // snapshot keeps showing until DONE reloads it
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= BCD_IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      step_q <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (st_q)
        BCD_IDLE: begin
          if (frame_b) begin
            bin_q  <= src;
            bcd_q  <= '0;
            step_q <= '0;
            st_q   <= BCD_CONV;
          end
        end
        BCD_CONV: begin
          bcd_q  <= {bcd_adj[38:0], bin_q[31]};
          bin_q  <= {bin_q[30:0], 1'b0};
          step_q <= step_q + 5'd1;
          if (step_q == 5'd31) st_q <= BCD_DONE;
        end
        BCD_DONE: begin
          snap_q <= bcd_q[31:0];
          ovf_q  <= |bcd_q[39:32];
          st_q   <= BCD_IDLE;
        end
        default: st_q <= BCD_IDLE;
      endcase
    end
  end

  // Conversion must finish within one frame
  always_ff @(posedge clk) begin
    if (!rst)
      assert (SCAN_DIV * 8 > 34)
        else $error("SCAN_DIV too small for BCD");
  end

`else

  assign dp_on = 1'b0;

  always_ff @(posedge clk) begin
    if (rst)          snap_q <= '0;
    else if (frame_b) snap_q <= src;
  end

`endif

  assign cur_sel = sel_q;
  assign seg_an  = an_q;
  assign seg_cat = cat_q;

endmodule

// File: tb/tb_stat_disp_ctrl.sv
// Self-checking bench for stat_disp_ctrl: randomized sources
// against a digit-level reference of the display.
module tb_stat_disp_ctrl;

`ifdef STAT_DISP_BCD_EN
  localparam int SCAN = 8;
`else
  localparam int SCAN = 4;
`endif
  localparam int ROT   = 3;
  localparam int FRAME = 8 * SCAN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src [5];
  logic        sel_btn = 1'b0;
  logic        auto_en = 1'b0;
  logic [2:0]  cur_sel;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  int checks = 0;
  int errors = 0;
  int exp_sel = 0;

  logic [6:0] segtab [16];
  logic [7:0] frame_cat [8];

  stat_disp_ctrl #(
    .SCAN_DIV     (SCAN),
    .ROTATE_TICKS (ROT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .total_cycles  (src[0]),
    .uncondi_num   (src[1]),
    .condi_num     (src[2]),
    .condi_suc_num (src[3]),
    .SyscallOut    (src[4]),
    .sel_btn       (sel_btn),
    .auto_en       (auto_en),
    .cur_sel       (cur_sel),
    .seg_an        (seg_an),
    .seg_cat       (seg_cat)
  );

  always #5 clk = ~clk;

  // Reference: hex digit i of v with dp off
  function automatic logic [7:0] hex_cat(
    input logic [31:0] v, input int i
  );
    logic [3:0] n;
    n = 4'((v >> (4 * i)) & 32'hF);
    return {1'b1, segtab[n]};
  endfunction

  // Reference: decimal digit i of v, dp on digit 7 if v>1e8-1
  function automatic logic [7:0] dec_cat(
    input logic [31:0] v, input int i
  );
    longint unsigned x;
    logic            dp;
    x = 64'(v) % 64'd100000000;
    for (int k = 0; k < i; k++) x = x / 10;
    dp = (i == 7) && (v > 32'd99999999);
    return {~dp, segtab[4'(x % 10)]};
  endfunction

  // Returns at the negedge right after a frame boundary edge
  task automatic wait_boundary(input string tag);
    int n;
    n = 0;
    while (seg_an === 8'h7F && n < 4 * FRAME) begin
      @(negedge clk); n++;
    end
    while (seg_an !== 8'h7F && n < 4 * FRAME) begin
      @(negedge clk); n++;
    end
    if (seg_an !== 8'h7F) begin
      checks++; errors++;
      $display("FAIL %s boundary timeout an=%h want 7f",
               tag, seg_an);
    end
  endtask

  task automatic capture_frame(
    input string       tag,
    input bit          chg,
    input logic [31:0] nv
  );
    logic [7:0] want;
    int         n;
    wait_boundary(tag);
    n = 0;
    while (seg_an !== 8'hFE && n < 2 * SCAN) begin
      @(negedge clk); n++;
    end
    frame_cat[0] = seg_cat;
    for (int i = 1; i < 8; i++) begin
      want = ~(8'd1 << i);
      n = 0;
      while (seg_an !== want && n < 2 * SCAN) begin
        @(negedge clk); n++;
      end
      if (seg_an !== want) begin
        checks++; errors++;
        $display("FAIL %s digit%0d an=%h want %h",
                 tag, i, seg_an, want);
      end
      frame_cat[i] = seg_cat;
      if (chg && i == 3) src[2] = nv;
    end
  endtask

  task automatic press_btn();
    sel_btn = 1'b1;
    repeat (10) @(negedge clk);
    sel_btn = 1'b0;
    repeat (10) @(negedge clk);
    exp_sel = (exp_sel + 1) % 5;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (seg_an !== 8'hFF || seg_cat !== 8'hFF ||
          cur_sel !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold an=%h cat=%h sel=%0d want ff ff 0",
                 seg_an, seg_cat, cur_sel);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= SCAN; c++) begin
      @(negedge clk);
      checks++;
      if (c < SCAN) begin
        if (seg_an !== 8'hFF || seg_cat !== 8'hFF ||
            cur_sel !== 3'd0) begin
          errors++;
          $display("FAIL reset_blank c=%0d an=%h cat=%h want ff ff",
                   c, seg_an, seg_cat);
        end
      end else if (seg_an !== 8'hFE || seg_cat !== 8'hC0) begin
        errors++;
        $display("FAIL reset_first an=%h cat=%h want fe c0",
                 seg_an, seg_cat);
      end
    end
  endtask

  task automatic test_hex_frame();
    for (int s = 0; s < 5; s++) src[s] = $urandom;
    src[0] = 32'h1234ABCD;
    for (int f = 0; f < 2; f++) begin
      capture_frame("hex", 1'b0, 32'd0);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (frame_cat[i] !== hex_cat(src[0], i)) begin
          errors++;
          $display("FAIL hex f%0d d%0d got %h want %h",
                   f, i, frame_cat[i], hex_cat(src[0], i));
        end
      end
    end
    checks++;
    if (frame_cat[0][6:0] !== 7'h21 ||
        frame_cat[7][6:0] !== 7'h79) begin
      errors++;
      $display("FAIL hex_ends d0=%h d7=%h want 21 79",
               frame_cat[0][6:0], frame_cat[7][6:0]);
    end
  endtask

  task automatic test_button_wrap();
    for (int p = 0; p < 5; p++) begin
      sel_btn = 1'b1;
      repeat (10) @(negedge clk);
      exp_sel = (exp_sel + 1) % 5;
      checks++;
      if (cur_sel !== 3'(exp_sel)) begin
        errors++;
        $display("FAIL btn_hi p%0d sel=%0d want %0d",
                 p, cur_sel, exp_sel);
      end
      sel_btn = 1'b0;
      repeat ($urandom_range(4, 12)) @(negedge clk);
      checks++;
      if (cur_sel !== 3'(exp_sel)) begin
        errors++;
        $display("FAIL btn_lo p%0d sel=%0d want %0d",
                 p, cur_sel, exp_sel);
      end
    end
  endtask

  task automatic test_random_frames();
    int np;
    for (int it = 0; it < 4; it++) begin
      for (int s = 0; s < 5; s++) src[s] = $urandom;
      np = $urandom_range(0, 4);
      for (int k = 0; k < np; k++) press_btn();
      capture_frame("rnd", 1'b0, 32'd0);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (frame_cat[i] !== hex_cat(src[exp_sel], i)) begin
          errors++;
          $display("FAIL rnd it%0d sel%0d d%0d got %h want %h",
                   it, exp_sel, i, frame_cat[i],
                   hex_cat(src[exp_sel], i));
        end
      end
    end
  endtask

  task automatic test_anti_tear();
    logic [31:0] a, b;
    while (exp_sel != 2) press_btn();
    a = $urandom;
    b = ~a;
    src[2] = a;
    capture_frame("tear", 1'b1, b);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (frame_cat[i] !== hex_cat(a, i)) begin
        errors++;
        $display("FAIL tear_cur d%0d got %h want %h",
                 i, frame_cat[i], hex_cat(a, i));
      end
    end
    capture_frame("tear2", 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (frame_cat[i] !== hex_cat(b, i)) begin
        errors++;
        $display("FAIL tear_next d%0d got %h want %h",
                 i, frame_cat[i], hex_cat(b, i));
      end
    end
  endtask

  task automatic test_rotate_collision();
    auto_en = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      wait_boundary("rot");
      if (b == 2) begin
        // btn edge reaches the event stage on the rot edge
        repeat (FRAME - 3) @(negedge clk);
        sel_btn = 1'b1;
      end
      if (b == 3 || b == 6) exp_sel = (exp_sel + 1) % 5;
      if (b == 3) begin
        repeat (8) @(negedge clk);
        sel_btn = 1'b0;
      end
      checks++;
      if (cur_sel !== 3'(exp_sel)) begin
        errors++;
        $display("FAIL rot_b%0d sel=%0d want %0d",
                 b, cur_sel, exp_sel);
      end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    press_btn();
    repeat ($urandom_range(1, FRAME)) @(negedge clk);
    rst = 1'b1;
    exp_sel = 0;
    @(negedge clk);
    checks++;
    if (seg_an !== 8'hFF || seg_cat !== 8'hFF ||
        cur_sel !== 3'd0) begin
      errors++;
      $display("FAIL midrst an=%h cat=%h sel=%0d want ff ff 0",
               seg_an, seg_cat, cur_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (SCAN - 1) @(negedge clk);
    checks++;
    if (seg_an !== 8'hFF || seg_cat !== 8'hFF) begin
      errors++;
      $display("FAIL midrst_blank an=%h cat=%h want ff ff",
               seg_an, seg_cat);
    end
    @(negedge clk);
    checks++;
    if (seg_an !== 8'hFE || seg_cat !== 8'hC0) begin
      errors++;
      $display("FAIL midrst_first an=%h cat=%h want fe c0",
               seg_an, seg_cat);
    end
  endtask

`ifdef STAT_DISP_BCD_EN
  task automatic test_bcd();
    logic [31:0] v;
    logic [7:0]  w;
    while (exp_sel != 4) press_btn();
    src[4] = 32'd123456789;
    capture_frame("bcd0", 1'b0, 32'd0);
    capture_frame("bcd1", 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (frame_cat[i] !== dec_cat(src[4], i)) begin
        errors++;
        $display("FAIL bcd d%0d got %h want %h",
                 i, frame_cat[i], dec_cat(src[4], i));
      end
    end
    // New value lands 34 cycles after the boundary: digits
    // 0..3 of that frame still show the old value
    v = src[4];
    src[4] = 32'd11111111;
    capture_frame("bcd2", 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      w = (i < 4) ? dec_cat(v, i) : dec_cat(src[4], i);
      checks++;
      if (frame_cat[i] !== w) begin
        errors++;
        $display("FAIL bcd_lat d%0d got %h want %h",
                 i, frame_cat[i], w);
      end
    end
  endtask
`endif

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30,
               7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03,
               7'h46, 7'h21, 7'h06, 7'h0E};
    for (int s = 0; s < 5; s++) src[s] = 32'd0;
    test_reset();
`ifdef STAT_DISP_BCD_EN
    test_button_wrap();
    test_bcd();
`else
    test_hex_frame();
    test_button_wrap();
    test_random_frames();
    test_anti_tear();
    test_rotate_collision();
    test_mid_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
